// File: rtl/mem_xfer_fsm_pkg.sv
// Shared types for the memory-transfer controller: FSM state encoding and mode constants.
package mem_xfer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR  = 4'd1,
    ST_DATA  = 4'd2,
    ST_MEM   = 4'd3,
    ST_WAIT  = 4'd4,
    ST_LATCH = 4'd5,
    ST_WB    = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } state_e;

  localparam logic MODE_STORE = 1'b0;
  localparam logic MODE_LOAD  = 1'b1;

endpackage

// File: rtl/mem_xfer_fsm_if.sv
// Bundle of decoder request, memory completion and datapath strobes for mem_xfer_fsm.
// valid/ready: start is a one-cycle request accepted only while busy=0; done/error are one-cycle responses.
interface mem_xfer_fsm_if #(
  parameter int NUM_REGS = 6,
  parameter int SEL_W    = 6
);
  import mem_xfer_pkg::*;

  logic                start;
  logic                is_load;
  logic [SEL_W-1:0]    ri;
  logic [SEL_W-1:0]    rj;
  logic                mfc;
  logic [NUM_REGS-1:0] reg_read;
  logic [NUM_REGS-1:0] reg_write;
  logic                mar_write;
  logic                mem_en;
  logic                mem_rw;
  logic                mdr_write;
  logic                mdr_mem_read;
  logic                mdr_drive;
  logic                busy;
  logic                done;
  logic                error;
  state_e              dbg_state;

  modport master (
    output start, is_load, ri, rj, mfc,
    input  reg_read, reg_write, mar_write, mem_en, mem_rw, mdr_write,
           mdr_mem_read, mdr_drive, busy, done, error, dbg_state
  );

  modport slave (
    input  start, is_load, ri, rj, mfc,
    output reg_read, reg_write, mar_write, mem_en, mem_rw, mdr_write,
           mdr_mem_read, mdr_drive, busy, done, error, dbg_state
  );

endinterface

// File: rtl/mem_xfer_fsm_sel_decoder.sv
// Selector to one-hot register enable; out-of-range indices decode to all zeros.
module sel_decoder #(
  parameter int NUM_REGS = 6,
  parameter int SEL_W    = 6
) (
  input  logic [SEL_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = en_i && (32'(idx_i) == i);
    end
  end

endmodule

// File: rtl/mem_xfer_fsm.sv
// Store/load memory-transfer sequencer driving register file, MAR, MDR and memory strobes.
// Optional WAIT timeout enabled by defining MEM_XFER_TIMEOUT_EN.
module mem_xfer_fsm
  import mem_xfer_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int SEL_W    = 6,
  parameter int TIMEOUT  = 15
) (
  input  logic clk,
  input  logic reset_n,
  mem_xfer_fsm_if.slave bus
);

  state_e           state_q, state_d;
  logic             is_load_q, is_load_d;
  logic [SEL_W-1:0] ri_q, ri_d;
  logic [SEL_W-1:0] rj_q, rj_d;

  logic             rd_en, wr_en;
  logic [SEL_W-1:0] rd_idx;
  logic             sel_bad;

  assign sel_bad = (32'(bus.ri) >= NUM_REGS) || (32'(bus.rj) >= NUM_REGS);

`ifdef MEM_XFER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_MEM) cnt_d = '0;
    else if (state_q == ST_WAIT && !bus.mfc && !expired) cnt_d = cnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      is_load_q <= 1'b0;
      ri_q      <= '0;
      rj_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      ri_q      <= ri_d;
      rj_q      <= rj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    ri_d      = ri_q;
    rj_d      = rj_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          is_load_d = bus.is_load;
          ri_d      = bus.ri;
          rj_d      = bus.rj;
          state_d   = sel_bad ? ST_ERR : ST_ADDR;
        end
      end
      ST_ADDR:  state_d = (is_load_q == MODE_LOAD) ? ST_MEM : ST_DATA;
      ST_DATA:  state_d = ST_MEM;
      ST_MEM:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mfc) begin
          state_d = (is_load_q == MODE_LOAD) ? ST_LATCH : ST_DONE;
        end
`ifdef MEM_XFER_TIMEOUT_EN
        else if (expired) begin
          state_d = ST_ERR;
        end
`endif
      end
      ST_LATCH: state_d = ST_WB;
      ST_WB:    state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Both decoders share the latched fields; only one is enabled in any state.
  always_comb begin
    rd_en            = (state_q == ST_ADDR) || (state_q == ST_DATA);
    rd_idx           = (state_q == ST_ADDR) ? rj_q : ri_q;
    wr_en            = (state_q == ST_WB);
    bus.mar_write    = (state_q == ST_ADDR);
    bus.mdr_write    = (state_q == ST_DATA);
    bus.mem_en       = (state_q == ST_MEM) || (state_q == ST_WAIT);
    bus.mem_rw       = bus.mem_en && (is_load_q == MODE_STORE);
    bus.mdr_mem_read = (state_q == ST_LATCH);
    bus.mdr_drive    = (state_q == ST_WB);
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = (state_q == ST_DONE);
    bus.error        = (state_q == ST_ERR);
    bus.dbg_state    = state_q;
  end

  sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_rd_dec (
    .idx_i    (rd_idx),
    .en_i     (rd_en),
    .onehot_o (bus.reg_read)
  );

  sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_wr_dec (
    .idx_i    (ri_q),
    .en_i     (wr_en),
    .onehot_o (bus.reg_write)
  );

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Directed testbench for mem_xfer_fsm with default parameters (NUM_REGS=6, SEL_W=6, TIMEOUT=15).
module tb_mem_xfer_fsm;
  import mem_xfer_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  mem_xfer_fsm_if #(.NUM_REGS(6), .SEL_W(6)) bus ();

  mem_xfer_fsm #(.NUM_REGS(6), .SEL_W(6), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg_read, reg_write, mar, mem_en, mem_rw, mdr_write, mdr_mem_read, mdr_drive, busy, done, error}
  function automatic logic [20:0] outs();
    return {bus.reg_read, bus.reg_write, bus.mar_write, bus.mem_en, bus.mem_rw,
            bus.mdr_write, bus.mdr_mem_read, bus.mdr_drive, bus.busy, bus.done, bus.error};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [5:0] ri, input logic [5:0] rj);
    bus.start   = 1'b1;
    bus.is_load = ld;
    bus.ri      = ri;
    bus.rj      = rj;
    step();
    bus.start   = 1'b0;
    bus.is_load = 1'b0;
    bus.ri      = '0;
    bus.rj      = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0; bus.is_load = 1'b0; bus.ri = '0; bus.rj = '0; bus.mfc = 1'b0;
    #3;
    checks++;
    if (outs() !== 21'd0) begin
      errors++; $display("FAIL reset_outs: got %h want 0", outs());
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE);
    end
    #4 reset_n = 1'b1;
    step();
  endtask

  task automatic test_store();
    logic [20:0] exp_o [1:8];
    state_e      exp_s [1:8];
    exp_o[1] = {6'b010000, 6'b0, 9'b100000100}; exp_s[1] = ST_ADDR;
    exp_o[2] = {6'b000100, 6'b0, 9'b000100100}; exp_s[2] = ST_DATA;
    exp_o[3] = {6'b0,      6'b0, 9'b011000100}; exp_s[3] = ST_MEM;
    exp_o[4] = {6'b0,      6'b0, 9'b011000100}; exp_s[4] = ST_WAIT;
    exp_o[5] = {6'b0,      6'b0, 9'b011000100}; exp_s[5] = ST_WAIT;
    exp_o[6] = {6'b0,      6'b0, 9'b011000100}; exp_s[6] = ST_WAIT;
    exp_o[7] = {6'b0,      6'b0, 9'b000000110}; exp_s[7] = ST_DONE;
    exp_o[8] = 21'd0;                           exp_s[8] = ST_IDLE;
    issue(MODE_STORE, 6'd2, 6'd4);
    for (int c = 1; c <= 8; c++) begin
      bus.mfc = (c == 6);
      checks++;
      if (outs() !== exp_o[c] || bus.dbg_state !== exp_s[c]) begin
        errors++;
        $display("FAIL store_c%0d: got outs=%h st=%0d want outs=%h st=%0d",
                 c, outs(), bus.dbg_state, exp_o[c], exp_s[c]);
      end
      step();
    end
    bus.mfc = 1'b0;
  endtask

  task automatic test_load();
    logic [20:0] exp_o [1:7];
    state_e      exp_s [1:7];
    exp_o[1] = {6'b000001, 6'b0,      9'b100000100}; exp_s[1] = ST_ADDR;
    exp_o[2] = {6'b0,      6'b0,      9'b010000100}; exp_s[2] = ST_MEM;
    exp_o[3] = {6'b0,      6'b0,      9'b010000100}; exp_s[3] = ST_WAIT;
    exp_o[4] = {6'b0,      6'b0,      9'b000010100}; exp_s[4] = ST_LATCH;
    exp_o[5] = {6'b0,      6'b000010, 9'b000001100}; exp_s[5] = ST_WB;
    exp_o[6] = {6'b0,      6'b0,      9'b000000110}; exp_s[6] = ST_DONE;
    exp_o[7] = 21'd0;                                exp_s[7] = ST_IDLE;
    bus.mfc = 1'b1;
    issue(MODE_LOAD, 6'd1, 6'd0);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (outs() !== exp_o[c] || bus.dbg_state !== exp_s[c]) begin
        errors++;
        $display("FAIL load_c%0d: got outs=%h st=%0d want outs=%h st=%0d",
                 c, outs(), bus.dbg_state, exp_o[c], exp_s[c]);
      end
      step();
    end
    bus.mfc = 1'b0;
  endtask

  task automatic test_bad_sel();
    issue(MODE_STORE, 6'd7, 6'd3);
    checks++;
    if (outs() !== {12'b0, 9'b000000101} || bus.dbg_state !== ST_ERR) begin
      errors++; $display("FAIL badsel_c1: got outs=%h st=%0d want outs=%h st=%0d",
                         outs(), bus.dbg_state, {12'b0, 9'b000000101}, ST_ERR);
    end
    step();
    checks++;
    if (outs() !== 21'd0 || bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL badsel_c2: got outs=%h st=%0d want 0/IDLE", outs(), bus.dbg_state);
    end
    issue(MODE_LOAD, 6'd0, 6'd6);
    checks++;
    if (bus.error !== 1'b1 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL badsel_rj: got error=%b mem_en=%b want 1/0", bus.error, bus.mem_en);
    end
    step();
  endtask

  task automatic test_timeout();
    int done_seen;
    int wait_cnt;
    done_seen = 0;
    wait_cnt  = 0;
    bus.mfc   = 1'b0;
    issue(MODE_STORE, 6'd3, 6'd5);
    for (int c = 1; c <= 19; c++) begin
      if (bus.dbg_state == ST_WAIT) wait_cnt++;
      if (bus.done) done_seen++;
      step();
    end
    checks++;
    if (wait_cnt !== 16) begin
      errors++; $display("FAIL timeout_wait_cycles: got %0d want 16", wait_cnt);
    end
`ifdef MEM_XFER_TIMEOUT_EN
    checks++;
    if (bus.dbg_state !== ST_ERR || bus.error !== 1'b1 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL timeout_err: got st=%0d error=%b mem_en=%b want ERR/1/0",
                         bus.dbg_state, bus.error, bus.mem_en);
    end
    step();
    step();
`else
    for (int c = 0; c < 10; c++) step();
    checks++;
    if (bus.dbg_state !== ST_WAIT || bus.error !== 1'b0 || bus.mem_en !== 1'b1) begin
      errors++; $display("FAIL no_timeout_wait: got st=%0d error=%b mem_en=%b want WAIT/0/1",
                         bus.dbg_state, bus.error, bus.mem_en);
    end
    bus.mfc = 1'b1;
    step();
    if (bus.done) done_seen++;
    bus.mfc = 1'b0;
    done_seen = done_seen - 1;
    step();
`endif
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL timeout_no_done: got %0d extra done pulses want 0", done_seen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.mfc = 1'b0;
    issue(MODE_STORE, 6'd1, 6'd2);
    step(); step(); step();
    checks++;
    if (bus.dbg_state !== ST_WAIT) begin
      errors++; $display("FAIL rst_mid_pre: got st=%0d want WAIT", bus.dbg_state);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 21'd0 || bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid_async: got outs=%h st=%0d want 0/IDLE", outs(), bus.dbg_state);
    end
    #1 reset_n = 1'b1;
    step();
    checks++;
    if (outs() !== 21'd0) begin
      errors++; $display("FAIL rst_mid_no_pulse: got outs=%h want 0", outs());
    end
    bus.mfc = 1'b1;
    issue(MODE_STORE, 6'd5, 6'd0);
    n = 1;
    while (!bus.done && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL rst_mid_store_latency: got %0d want 5", n);
    end
    bus.mfc = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int dones;
    dones       = 0;
    bus.mfc     = 1'b1;
    bus.start   = 1'b1;
    bus.is_load = MODE_STORE;
    bus.ri      = 6'd0;
    bus.rj      = 6'd1;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (bus.done) dones++;
      if (c == 6) begin
        checks++;
        if (bus.dbg_state !== ST_IDLE || bus.busy !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_c6: got st=%0d busy=%b want IDLE/0", bus.dbg_state, bus.busy);
        end
      end
      step();
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL b2b_done_count: got %0d want 1", dones);
    end
    checks++;
    if (bus.dbg_state !== ST_ADDR || bus.reg_read !== 6'b000010) begin
      errors++; $display("FAIL b2b_second_start: got st=%0d reg_read=%b want ADDR/000010",
                         bus.dbg_state, bus.reg_read);
    end
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL b2b_end_idle: got st=%0d want IDLE", bus.dbg_state);
    end
    bus.mfc = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_store();
    test_load();
    test_bad_sel();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
